cfg_shift_bridge: RTL and testbench

CFG_SHIFT_BRIDGE -- requirements
Module: cfg_shift_bridge

---
 rtl/cfg_shift_bridge.sv | 257 +++++++++++++++++++++++++
 tb/tb_cfg_shift_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_shift_bridge.sv
// cfg_shift_bridge: writes a static and a dynamic configuration image to a
// serial target over a gated clock (sclk/mosi/sel). Each bit is H CLK cycles
// low followed by H CLK cycles high, MSB first.
//
// Optional feature: define CFG_BRIDGE_READBACK_EN to add readback frames
// (RD_STAT/RD_DYN), miso comparison and slow-speed retries. Without it, the
// sequence ends after GAP2 with pass=1 and the readback status is tied to 0.
module cfg_shift_bridge #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int DIVW       = 8,
  parameter int MAXRETRY   = 3,
  localparam int RW        = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [SIZESRSTAT-1:0] stat_data,
  input  logic [SIZESRDYN-1:0]  dyn_data,
  input  logic [DIVW-1:0]       div_fast,
  input  logic [DIVW-1:0]       div_slow,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [RW-1:0]         retry_cnt,
  output logic                  mismatch_stat,
  output logic                  mismatch_dyn
);

  // Bit counter only has to index the longer (static) image.
  localparam int BW = (SIZESRSTAT > 1) ? $clog2(SIZESRSTAT) : 1;

  typedef enum logic [3:0] {
    IDLE, WR_STAT, GAP1, WR_DYN, GAP2, RD_STAT, GAP3, RD_DYN, CHECK, DONE
  } state_t;

  state_t                state;
  logic [SIZESRSTAT-1:0] sh;        // remaining bits of the current frame, current bit at MSB
  logic [SIZESRDYN-1:0]  dyn_q;
  logic [DIVW-1:0]       h_m1;      // active half-period minus one
  logic [DIVW-1:0]       hcnt;      // cycles elapsed in the current half-period
  logic                  ph;        // 0: first half (sclk low / gap part 1), 1: second half
  logic [BW-1:0]         bcnt;      // bits left after the current one

  logic [SIZESRSTAT-1:0] sh_shift;
  logic [SIZESRSTAT-1:0] dyn_img;
  logic                  last_cycle;

`ifdef CFG_BRIDGE_READBACK_EN
  logic [SIZESRSTAT-1:0] stat_q;
  logic [DIVW-1:0]       slow_m1;
  logic [RW-1:0]         retry_q;
  logic                  mm_stat_q;
  logic                  mm_dyn_q;

  assign retry_cnt     = retry_q;
  assign mismatch_stat = mm_stat_q;
  assign mismatch_dyn  = mm_dyn_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{miso, div_slow};
  assign retry_cnt     = '0;
  assign mismatch_stat = 1'b0;
  assign mismatch_dyn  = 1'b0;
`endif

  // A divisor of 0 behaves as 1, so the stored value is max(d,1)-1.
  function automatic logic [DIVW-1:0] half_m1(input logic [DIVW-1:0] d);
    return (d == '0) ? '0 : d - DIVW'(1);
  endfunction

  // Shift helper, left-aligned dynamic image and end-of-half-period detect.
  // NOTE: every signal gets a value on every path of always_comb, so no latch is inferred.
  always_comb begin
    sh_shift   = sh << 1;
    dyn_img    = SIZESRSTAT'(dyn_q) << (SIZESRSTAT - SIZESRDYN);
    last_cycle = (hcnt == h_m1);
  end

  // Sequencer: state, frame timing, serial outputs and status, all registered.
  // NOTE: sequential state is written with non-blocking assignments only, so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      sh    <= '0;
      dyn_q <= '0;
      h_m1  <= '0;
      hcnt  <= '0;
      ph    <= 1'b0;
      bcnt  <= '0;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
      sel   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      fail  <= 1'b0;
`ifdef CFG_BRIDGE_READBACK_EN
      stat_q    <= '0;
      slow_m1   <= '0;
      retry_q   <= '0;
      mm_stat_q <= 1'b0;
      mm_dyn_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dyn_q <= dyn_data;
            h_m1  <= half_m1(div_fast);
            busy  <= 1'b1;
            pass  <= 1'b0;
            fail  <= 1'b0;
`ifdef CFG_BRIDGE_READBACK_EN
            stat_q    <= stat_data;
            slow_m1   <= half_m1(div_slow);
            retry_q   <= '0;
            mm_stat_q <= 1'b0;
            mm_dyn_q  <= 1'b0;
`endif
            hcnt  <= '0;
            ph    <= 1'b0;
            bcnt  <= BW'(SIZESRSTAT - 1);
            sh    <= stat_data;
            mosi  <= stat_data[SIZESRSTAT-1];
            sclk  <= 1'b0;
            sel   <= 1'b1;
            state <= WR_STAT;
          end
        end

        WR_STAT, WR_DYN, RD_STAT, RD_DYN: begin
          if (!last_cycle) begin
            hcnt <= hcnt + DIVW'(1);
          end else begin
            hcnt <= '0;
            if (!ph) begin
              // Low phase over: raise sclk; readback samples miso on this edge.
              ph   <= 1'b1;
              sclk <= 1'b1;
`ifdef CFG_BRIDGE_READBACK_EN
              if (miso != mosi) begin
                if (state == RD_STAT) mm_stat_q <= 1'b1;
                if (state == RD_DYN)  mm_dyn_q  <= 1'b1;
              end
`endif
            end else if (bcnt != '0) begin
              // High phase over: next bit starts its low phase.
              ph   <= 1'b0;
              sclk <= 1'b0;
              bcnt <= bcnt - BW'(1);
              sh   <= sh_shift;
              mosi <= sh_shift[SIZESRSTAT-1];
            end else begin
              // Last high phase over: close the frame.
              ph   <= 1'b0;
              sclk <= 1'b0;
              sel  <= 1'b0;
              mosi <= 1'b0;
              case (state)
                WR_STAT: state <= GAP1;
                WR_DYN:  state <= GAP2;
                RD_STAT: state <= GAP3;
                default: state <= CHECK;
              endcase
            end
          end
        end

        GAP1, GAP2, GAP3: begin
          // Two half-periods with sel low, counted with the same phase bit.
          if (!last_cycle) begin
            hcnt <= hcnt + DIVW'(1);
          end else begin
            hcnt <= '0;
            if (!ph) begin
              ph <= 1'b1;
            end else begin
              ph <= 1'b0;
              case (state)
                GAP1: begin
                  sh    <= dyn_img;
                  mosi  <= dyn_img[SIZESRSTAT-1];
                  bcnt  <= BW'(SIZESRDYN - 1);
                  sel   <= 1'b1;
                  state <= WR_DYN;
                end
                GAP2: begin
`ifdef CFG_BRIDGE_READBACK_EN
                  sh    <= stat_q;
                  mosi  <= stat_q[SIZESRSTAT-1];
                  bcnt  <= BW'(SIZESRSTAT - 1);
                  sel   <= 1'b1;
                  state <= RD_STAT;
`else
                  pass  <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
`endif
                end
                default: begin
                  sh    <= dyn_img;
                  mosi  <= dyn_img[SIZESRSTAT-1];
                  bcnt  <= BW'(SIZESRDYN - 1);
                  sel   <= 1'b1;
                  state <= RD_DYN;
                end
              endcase
            end
          end
        end

`ifdef CFG_BRIDGE_READBACK_EN
        CHECK: begin
          if (!mm_stat_q && !mm_dyn_q) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (retry_q < RW'(MAXRETRY)) begin
            // Retry the whole sequence at the slow half-period.
            retry_q   <= retry_q + RW'(1);
            h_m1      <= slow_m1;
            mm_stat_q <= 1'b0;
            mm_dyn_q  <= 1'b0;
            sh        <= stat_q;
            mosi      <= stat_q[SIZESRSTAT-1];
            bcnt      <= BW'(SIZESRSTAT - 1);
            sel       <= 1'b1;
            state     <= WR_STAT;
          end else begin
            // Out of retries: the mismatch flags of the last attempt stay visible.
            fail  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
`endif

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_shift_bridge.sv
// Self-checking bench for cfg_shift_bridge. A cycle-stream model built from the
// frame/gap/done timing rules is compared against the DUT every cycle; literal
// expectations pin frame lengths, done pulses and final status. Readback
// scenarios are included when CFG_BRIDGE_READBACK_EN is defined.
module tb_cfg_shift_bridge;

  localparam int SS = 88;
  localparam int SD = 16;
  localparam int MR = 3;
  localparam int ECHO    = 0;
  localparam int STUCK0  = 1;
  localparam int CORRUPT = 2;
`ifdef CFG_BRIDGE_READBACK_EN
  localparam int FRAMES = 4;
`else
  localparam int FRAMES = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [87:0] stat_data = '0;
  logic [15:0] dyn_data = '0;
  logic [7:0]  div_fast = '0;
  logic [7:0]  div_slow = '0;
  logic        miso = 1'b0;
  logic        sclk, mosi, sel, busy, done, pass, fail;
  logic [1:0]  retry_cnt;
  logic        mismatch_stat, mismatch_dyn;

  cfg_shift_bridge dut (
    .CLK(clk), .RST_N(rst_n), .start(start),
    .stat_data(stat_data), .dyn_data(dyn_data),
    .div_fast(div_fast), .div_slow(div_slow), .miso(miso),
    .sclk(sclk), .mosi(mosi), .sel(sel), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .retry_cnt(retry_cnt),
    .mismatch_stat(mismatch_stat), .mismatch_dyn(mismatch_dyn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sel;
    logic sclk;
    logic mosi;
    logic busy;
    logic done;
  } obs_t;

  obs_t exp_q[$];
  obs_t model_q[$];
  int   total = 0;
  int   bad = 0;
  int   runs[$];
  int   run_len = 0;
  int   done_cnt = 0;
  int   hi_len = 0;
  int   last_hi = 0;
  int   tgt_mode = ECHO;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle compare against the model stream, plus sel/sclk/done monitors.
  initial begin : cmp
    obs_t o;
    forever begin
      @(negedge clk);
      o = {sel, sclk, mosi, busy, done};
      if (exp_q.size() != 0) check("stream", 32'(o), 32'(exp_q.pop_front()));
      else check("idle", 32'(o), 32'd0);
      if (sel) run_len++;
      else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end
      if (sclk) hi_len++;
      else if (hi_len > 0) begin last_hi = hi_len; hi_len = 0; end
      if (done) done_cnt++;
    end
  end

  // Serial target: remembers written bits per register, plays them back in
  // read frames. CORRUPT stores inverted bits when the low phase is under 2 cycles.
  initial begin : target
    logic st_mem [0:SS-1];
    logic dy_mem [0:SD-1];
    int   frame, nb, j, lowcnt;
    logic prev_sel, prev_sclk;
    frame = -1; nb = 0; j = 0; lowcnt = 0; prev_sel = 1'b0; prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        frame = -1; nb = 0; j = 0; lowcnt = 0;
        prev_sel = 1'b0; prev_sclk = 1'b0; miso = 1'b0;
      end else begin
        if (sel && !prev_sel) begin frame = (frame + 1) % 4; nb = 0; end
        if (sel && !sclk && (!prev_sel || prev_sclk)) begin
          j = nb; nb++; lowcnt = 0;
          if (tgt_mode == STUCK0) miso = 1'b0;
          else if (frame == 2 && j < SS) miso = st_mem[j];
          else if (frame == 3 && j < SD) miso = dy_mem[j];
          else miso = 1'b0;
        end
        if (sel && !sclk) lowcnt++;
        if (sel && sclk && !prev_sclk) begin
          if (frame == 0 && j < SS) st_mem[j] = mosi ^ (tgt_mode == CORRUPT && lowcnt < 2);
          if (frame == 1 && j < SD) dy_mem[j] = mosi ^ (tgt_mode == CORRUPT && lowcnt < 2);
        end
        prev_sel = sel; prev_sclk = sclk;
      end
    end
  end

  task automatic push_n(input obs_t o, input int n);
    repeat (n) model_q.push_back(o);
  endtask

  task automatic push_frame(input logic [87:0] v, input int len, input int h);
    for (int i = len - 1; i >= 0; i--) begin
      push_n({1'b1, 1'b0, v[i], 1'b1, 1'b0}, h);
      push_n({1'b1, 1'b1, v[i], 1'b1, 1'b0}, h);
    end
  endtask

  // Expected output stream for one accepted start, from the timing rules.
  task automatic model_run(input logic [87:0] st, input logic [15:0] dy,
                           input int df, input int ds, input int mode,
                           output int e_pass, output int e_fail, output int e_retry,
                           output int e_ms, output int e_md);
    int h, r, ms, md;
    bit fin;
    h = (df == 0) ? 1 : df;
    r = 0; fin = 0; ms = 0; md = 0;
    e_pass = 0; e_fail = 0; e_ms = 0; e_md = 0;
    model_q.delete();
    while (!fin) begin
      push_frame(st, SS, h);
      push_n(5'b00010, 2 * h);
      push_frame({72'b0, dy}, SD, h);
      push_n(5'b00010, 2 * h);
`ifdef CFG_BRIDGE_READBACK_EN
      push_frame(st, SS, h);
      push_n(5'b00010, 2 * h);
      push_frame({72'b0, dy}, SD, h);
      push_n(5'b00010, 1);
      case (mode)
        ECHO:    begin ms = 0; md = 0; end
        STUCK0:  begin ms = (st != 0); md = (dy != 0); end
        default: begin ms = (h < 2); md = (h < 2); end
      endcase
      if (!ms && !md) begin e_pass = 1; fin = 1; end
      else if (r < MR) begin r++; h = (ds == 0) ? 1 : ds; end
      else begin e_fail = 1; e_ms = ms; e_md = md; fin = 1; end
`else
      e_pass = 1; fin = (mode >= 0) || (ds >= 0);
`endif
    end
    e_retry = r;
    push_n(5'b00011, 1);
  endtask

  // One start; optionally a second start at cycle second_at, or reset at abort_at.
  task automatic run_seq(input logic [87:0] st, input logic [15:0] dy,
                         input logic [7:0] df, input logic [7:0] ds, input int mode,
                         input int second_at, input int abort_at);
    int e_pass, e_fail, e_retry, e_ms, e_md, cnt, budget;
    model_run(st, dy, int'(df), int'(ds), mode, e_pass, e_fail, e_retry, e_ms, e_md);
    runs.delete(); done_cnt = 0; tgt_mode = mode;
    stat_data = st; dyn_data = dy; div_fast = df; div_slow = ds;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 exp_q = model_q; start = 1'b0;
    budget = model_q.size() + 20;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      @(posedge clk); cnt++;
      if (cnt == second_at) begin
        #1 start = 1'b1; stat_data = ~st; div_fast = 8'd5;
        @(posedge clk); cnt++;
        #1 start = 1'b0;
      end
      if (cnt == abort_at) begin
        #2 exp_q.delete();
        check("pre_abort_sel", 32'(sel), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("abort_outs", 32'({sclk, sel, mosi, busy, done, pass, fail,
                                    mismatch_stat, mismatch_dyn, retry_cnt}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    if (exp_q.size() != 0) begin
      check("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk); #1;
    check("pass_model", 32'(pass), 32'(e_pass));
    check("fail_model", 32'(fail), 32'(e_fail));
    check("retry_model", 32'(retry_cnt), 32'(e_retry));
    check("mm_stat_model", 32'(mismatch_stat), 32'(e_ms));
    check("mm_dyn_model", 32'(mismatch_dyn), 32'(e_md));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("reset_outs", 32'({sclk, sel, mosi, busy, done, pass, fail,
                                mismatch_stat, mismatch_dyn, retry_cnt}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Spec vectors, H=1: 2*88 and 2*16 cycle frames, one done, pass.
    run_seq(88'h123456789ABCDEF1234567, 16'hABCD, 8'd1, 8'd1, ECHO, 0, 0);
    check("t1_frames", 32'(runs.size()), 32'(FRAMES));
    check("t1_stat_len", 32'(runs[0]), 32'd176);
    check("t1_dyn_len", 32'(runs[1]), 32'd32);
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_pass", 32'(pass), 32'd1);

    // H=3 with the other image pair.
    run_seq(88'hFEDCBA9876543210012345, 16'h4321, 8'd3, 8'd5, ECHO, 0, 0);
    check("t2_stat_len", 32'(runs[0]), 32'd528);
    check("t2_dyn_len", 32'(runs[1]), 32'd96);
    check("t2_retry", 32'(retry_cnt), 32'd0);

    // div_fast=0 acts as 1; a start while busy changes nothing.
    run_seq(88'hA5A5A5A5A5A5A5A5A5A5A5, 16'h0F0F, 8'd0, 8'd0, ECHO, 20, 0);
    check("t3_stat_len", 32'(runs[0]), 32'd176);
    check("t3_last_hi", 32'(last_hi), 32'd1);
    check("t3_done", 32'(done_cnt), 32'd1);

    // Reset during bit 40 of WR_STAT, then a full sequence afterwards.
    run_seq(88'hFEDCBA9876543210012345, 16'h4321, 8'd1, 8'd1, ECHO, 0, 80);
    repeat (3) @(negedge clk);
    run_seq(88'hFEDCBA9876543210012345, 16'h4321, 8'd2, 8'd2, ECHO, 0, 0);
    check("t4_stat_len", 32'(runs[0]), 32'd352);
    check("t4_done", 32'(done_cnt), 32'd1);
    check("t4_pass", 32'(pass), 32'd1);

`ifdef CFG_BRIDGE_READBACK_EN
    // miso stuck low: three slow retries, then fail with both flags.
    run_seq(88'hFEDCBA9876543210012345, 16'h4321, 8'd1, 8'd4, STUCK0, 0, 0);
    check("t5_fail", 32'(fail), 32'd1);
    check("t5_retry", 32'(retry_cnt), 32'd3);
    check("t5_mm", 32'({mismatch_stat, mismatch_dyn}), 32'd3);
    check("t5_frames", 32'(runs.size()), 32'd16);
    check("t5_last_hi", 32'(last_hi), 32'd4);

    // Target corrupts at H<2: one retry at H=2 passes.
    run_seq(88'hFEDCBA9876543210012345, 16'h4321, 8'd1, 8'd2, CORRUPT, 0, 0);
    check("t6_pass", 32'(pass), 32'd1);
    check("t6_retry", 32'(retry_cnt), 32'd1);
    check("t6_frames", 32'(runs.size()), 32'd8);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
